// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX stage: ALU-op encodings, control bundle width, $zero index.
package id_ex_reg_pkg;

  localparam int unsigned AOPW_DEF = 4;
  localparam int unsigned CTRL_W   = 6 + AOPW_DEF;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [AOPW_DEF-1:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_XOR = 4'h3,
    ALU_SLL = 4'h4,
    ALU_SRL = 4'h5,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_SRA = 4'h8,
    ALU_LUI = 4'h9,
    ALU_NOR = 4'hC
  } alu_op_e;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID-side inputs and EX-side registered outputs of the ID/EX pipeline register.
interface id_ex_reg_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned RW   = 5,
  parameter int unsigned AOPW = 4
);
  logic            id_valid;
  logic [DW-1:0]   id_pc4, id_rs_data, id_rt_data, id_imm_ext;
  logic [RW-1:0]   id_rs, id_rt, id_rd, id_shamt;
  logic            id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst;
  logic [AOPW-1:0] id_alu_op;

  logic            ex_valid;
  logic [DW-1:0]   ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [RW-1:0]   ex_rs, ex_rt, ex_rd, ex_shamt, ex_dest;
  logic            ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
  logic [AOPW-1:0] ex_alu_op;

  modport master (
    output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm_ext,
           id_rs, id_rt, id_rd, id_shamt,
           id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
           id_alu_op,
    input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
           ex_rs, ex_rt, ex_rd, ex_shamt, ex_dest,
           ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst,
           ex_alu_op
  );

  modport slave (
    input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm_ext,
           id_rs, id_rt, id_rd, id_shamt,
           id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
           id_alu_op,
    output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
           ex_rs, ex_rt, ex_rd, ex_shamt, ex_dest,
           ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst,
           ex_alu_op
  );
endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module id_ex_reg_load_use_detect
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          load_use
);

  // A load into $zero never produces a value worth waiting for.
  always_comb begin
    load_use = ex_valid && ex_mem_read && id_valid &&
               (ex_rt != RW'(REG_ZERO)) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, external stall and flush.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned RW   = 5,
  parameter int unsigned AOPW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  id_ex_reg_if.slave  bus,
  output logic        id_hold
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            reg_dst;
    logic [AOPW-1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm_ext;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [RW-1:0] shamt;
    ctrl_t         ctrl;
  } stage_t;

  stage_t ex_q, ex_d, id_in;
  logic   load_use;

  id_ex_reg_load_use_detect #(.RW(RW)) u_load_use_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl.mem_read),
    .ex_rt       (ex_q.rt),
    .id_valid    (bus.id_valid),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .load_use    (load_use)
  );

  always_comb begin
    id_in                 = '0;
    id_in.valid           = bus.id_valid;
    id_in.pc4             = bus.id_pc4;
    id_in.rs_data         = bus.id_rs_data;
    id_in.rt_data         = bus.id_rt_data;
    id_in.imm_ext         = bus.id_imm_ext;
    id_in.rs              = bus.id_rs;
    id_in.rt              = bus.id_rt;
    id_in.rd              = bus.id_rd;
    id_in.shamt           = bus.id_shamt;
    id_in.ctrl.reg_write  = bus.id_reg_write;
    id_in.ctrl.mem_to_reg = bus.id_mem_to_reg;
    id_in.ctrl.mem_read   = bus.id_mem_read;
    id_in.ctrl.mem_write  = bus.id_mem_write;
    id_in.ctrl.alu_src    = bus.id_alu_src;
    id_in.ctrl.reg_dst    = bus.id_reg_dst;
    id_in.ctrl.alu_op     = bus.id_alu_op;
  end

  // Flush outranks stall; a load-use bubble only applies when not stalled.
  always_comb begin
    ex_d = ex_q;
    if (flush || (!stall && load_use)) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d = id_in;
      if (!bus.id_valid) ex_d.ctrl = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign id_hold           = stall | load_use;

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc4        = ex_q.pc4;
  assign bus.ex_rs_data    = ex_q.rs_data;
  assign bus.ex_rt_data    = ex_q.rt_data;
  assign bus.ex_imm_ext    = ex_q.imm_ext;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_shamt      = ex_q.shamt;
  assign bus.ex_reg_write  = ex_q.ctrl.reg_write;
  assign bus.ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign bus.ex_mem_read   = ex_q.ctrl.mem_read;
  assign bus.ex_mem_write  = ex_q.ctrl.mem_write;
  assign bus.ex_alu_src    = ex_q.ctrl.alu_src;
  assign bus.ex_reg_dst    = ex_q.ctrl.reg_dst;
  assign bus.ex_alu_op     = ex_q.ctrl.alu_op;
  assign bus.ex_dest       = ex_q.ctrl.reg_dst ? ex_q.rd : ex_q.rt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a slot-level model of the ID/EX register.
module tb_id_ex_reg;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  logic id_hold;

  id_ex_reg_if #(.DW(32), .RW(5), .AOPW(4)) bus ();

  id_ex_reg #(.DW(32), .RW(5), .AOPW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .flush   (flush),
    .bus     (bus),
    .id_hold (id_hold)
  );

  typedef struct packed {
    bit        valid;
    bit [31:0] pc4;
    bit [31:0] rs_data;
    bit [31:0] rt_data;
    bit [31:0] imm;
    bit [4:0]  rs;
    bit [4:0]  rt;
    bit [4:0]  rd;
    bit [4:0]  shamt;
    bit        rw;
    bit        m2r;
    bit        mr;
    bit        mw;
    bit        asrc;
    bit        rdst;
    bit [3:0]  op;
  } slot_t;

  slot_t m;
  slot_t cur_in;
  bit    cur_st;
  bit    cur_fl;
  int    n_tests = 0;
  int    n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard(input slot_t e, input slot_t i);
    return e.valid && e.mr && i.valid && (e.rt != 5'd0) && ((e.rt == i.rs) || (e.rt == i.rt));
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.valid   = ($urandom_range(0, 3) != 0);
    s.pc4     = $urandom;
    s.rs_data = $urandom;
    s.rt_data = $urandom;
    s.imm     = $urandom;
    s.rs      = 5'($urandom_range(0, 7));
    s.rt      = 5'($urandom_range(0, 7));
    s.rd      = 5'($urandom_range(0, 31));
    s.shamt   = 5'($urandom_range(0, 31));
    s.rw      = 1'($urandom_range(0, 1));
    s.m2r     = 1'($urandom_range(0, 1));
    s.mr      = 1'($urandom_range(0, 1));
    s.mw      = 1'($urandom_range(0, 1));
    s.asrc    = 1'($urandom_range(0, 1));
    s.rdst    = 1'($urandom_range(0, 1));
    s.op      = 4'($urandom_range(0, 15));
    return s;
  endfunction

  task automatic drive(input slot_t s, input bit st, input bit fl);
    cur_in = s; cur_st = st; cur_fl = fl;
    stall = st; flush = fl;
    bus.id_valid      = s.valid;
    bus.id_pc4        = s.pc4;
    bus.id_rs_data    = s.rs_data;
    bus.id_rt_data    = s.rt_data;
    bus.id_imm_ext    = s.imm;
    bus.id_rs         = s.rs;
    bus.id_rt         = s.rt;
    bus.id_rd         = s.rd;
    bus.id_shamt      = s.shamt;
    bus.id_reg_write  = s.rw;
    bus.id_mem_to_reg = s.m2r;
    bus.id_mem_read   = s.mr;
    bus.id_mem_write  = s.mw;
    bus.id_alu_src    = s.asrc;
    bus.id_reg_dst    = s.rdst;
    bus.id_alu_op     = s.op;
  endtask

  // Spec rules: flush > stall > load-use bubble > normal load.
  task automatic model_update();
    if (cur_fl) m = '0;
    else if (cur_st) begin end
    else if (hazard(m, cur_in)) m = '0;
    else begin
      m = cur_in;
      if (!cur_in.valid) begin
        m.rw = 0; m.m2r = 0; m.mr = 0; m.mw = 0; m.asrc = 0; m.rdst = 0; m.op = '0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".valid"},   bus.ex_valid,      m.valid);
    check_eq({tag, ".pc4"},     bus.ex_pc4,        m.pc4);
    check_eq({tag, ".rs_data"}, bus.ex_rs_data,    m.rs_data);
    check_eq({tag, ".rt_data"}, bus.ex_rt_data,    m.rt_data);
    check_eq({tag, ".imm"},     bus.ex_imm_ext,    m.imm);
    check_eq({tag, ".rs"},      bus.ex_rs,         m.rs);
    check_eq({tag, ".rt"},      bus.ex_rt,         m.rt);
    check_eq({tag, ".rd"},      bus.ex_rd,         m.rd);
    check_eq({tag, ".shamt"},   bus.ex_shamt,      m.shamt);
    check_eq({tag, ".ctrl"},
             {bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read, bus.ex_mem_write,
              bus.ex_alu_src, bus.ex_reg_dst, bus.ex_alu_op},
             {m.rw, m.m2r, m.mr, m.mw, m.asrc, m.rdst, m.op});
    check_eq({tag, ".dest"},    bus.ex_dest,       m.rdst ? m.rd : m.rt);
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_cycle(input slot_t s, input bit st, input bit fl);
    drive(s, st, fl);
    @(negedge clk);
    check_state("cyc");
    check_eq("id_hold", id_hold, cur_st | hazard(m, cur_in));
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    slot_t z, a, b;
    z = '0;
    m = '0;
    rst_n = 1'b0;
    drive(z, 0, 0);
    repeat (2) @(negedge clk);
    check_state("reset");
    check_eq("reset_hold", id_hold, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through of a negative immediate
    a = z; a.valid = 1; a.imm = 32'hFFFF8000; a.asrc = 1; a.rt = 5'd2; a.pc4 = 32'h0000_0104;
    run_cycle(a, 0, 0);
    check_eq("pt_imm", bus.ex_imm_ext, 32'hFFFF8000);
    check_eq("pt_asrc", bus.ex_alu_src, 1'b1);
    check_eq("pt_valid", bus.ex_valid, 1'b1);

    // Load-use on rt=8
    a = z; a.valid = 1; a.mr = 1; a.m2r = 1; a.rw = 1; a.rt = 5'd8; a.op = 4'h2;
    run_cycle(a, 0, 0);
    b = z; b.valid = 1; b.rs = 5'd8; b.rt = 5'd3; b.rd = 5'd10; b.rw = 1; b.rdst = 1;
    drive(b, 0, 0);
    #1;
    check_eq("lu_hold", id_hold, 1'b1);
    run_cycle(b, 0, 0);
    check_eq("lu_bubble_valid", bus.ex_valid, 1'b0);
    check_eq("lu_bubble_mr", bus.ex_mem_read, 1'b0);
    run_cycle(b, 0, 0);
    check_eq("lu_load_valid", bus.ex_valid, 1'b1);
    check_eq("lu_load_rs", bus.ex_rs, 5'd8);

    // Load targeting $zero never stalls
    a = z; a.valid = 1; a.mr = 1; a.rw = 1; a.rt = 5'd0;
    run_cycle(a, 0, 0);
    b = z; b.valid = 1; b.rs = 5'd0; b.rt = 5'd0; b.rw = 1;
    drive(b, 0, 0);
    #1;
    check_eq("r0_hold", id_hold, 1'b0);
    run_cycle(b, 0, 0);
    check_eq("r0_valid", bus.ex_valid, 1'b1);

    // Back-to-back independent loads
    a = z; a.valid = 1; a.mr = 1; a.rt = 5'd8;
    run_cycle(a, 0, 0);
    b = z; b.valid = 1; b.mr = 1; b.rs = 5'd9; b.rt = 5'd4;
    drive(b, 0, 0);
    #1;
    check_eq("b2b_hold", id_hold, 1'b0);
    run_cycle(b, 0, 0);

    // Stall with flush, then a 3-cycle freeze
    a = z; a.valid = 1; a.rw = 1; a.pc4 = 32'h0000_0200; a.rd = 5'd7; a.rdst = 1;
    run_cycle(a, 0, 0);
    check_eq("sf_pre_rw", bus.ex_reg_write, 1'b1);
    run_cycle(rand_slot(), 1, 1);
    check_eq("sf_valid", bus.ex_valid, 1'b0);
    check_eq("sf_rw", bus.ex_reg_write, 1'b0);
    run_cycle(a, 0, 0);
    for (int unsigned i = 0; i < 3; i++) run_cycle(rand_slot(), 1, 0);
    check_eq("frz_pc4", bus.ex_pc4, 32'h0000_0200);
    check_eq("frz_valid", bus.ex_valid, 1'b1);

    // ex_dest mux
    a = z; a.valid = 1; a.rdst = 1; a.rd = 5'd5; a.rt = 5'd9;
    run_cycle(a, 0, 0);
    check_eq("dest_rd", bus.ex_dest, 5'd5);
    a.rdst = 0;
    run_cycle(a, 0, 0);
    check_eq("dest_rt", bus.ex_dest, 5'd9);

    // Asynchronous reset in the middle of a stall
    a = z; a.valid = 1; a.rw = 1; a.pc4 = 32'h0000_0300; a.rt = 5'd6;
    run_cycle(a, 0, 0);
    run_cycle(rand_slot(), 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m = '0;
    check_state("arst");
    drive(z, 0, 0);
    #1;
    check_eq("arst_hold", id_hold, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    // Randomized traffic
    for (int unsigned i = 0; i < 1500; i++) begin
      run_cycle(rand_slot(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      if (!bus.ex_valid)
        check_eq("bubble_guard", {bus.ex_reg_write, bus.ex_mem_write, bus.ex_mem_read}, 3'b000);
    end
    @(negedge clk);
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
